// File: rtl/vga_sync_if.sv
// Video timing bundle: sync pulses, pixel coordinate, display enable and strobes.
// f_tick is present only when VGA_SYNC_FRAME_TICK_EN is defined.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic       f_tick;
`endif

    modport master (
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
        , output f_tick
`endif
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, pixel_x, pixel_y
`ifdef VGA_SYNC_FRAME_TICK_EN
        , input f_tick
`endif
    );
endinterface

// File: rtl/vga_sync.sv
// 640x480 VGA timing generator: pixel-rate divider, h/v counters, registered sync.
// Optional frame strobe f_tick under VGA_SYNC_FRAME_TICK_EN.
module vga_sync #(
    parameter int DIV = 2,
    parameter int HD  = 640,
    parameter int HFP = 16,
    parameter int HSW = 96,
    parameter int HBP = 48,
    parameter int VD  = 480,
    parameter int VFP = 10,
    parameter int VSW = 2,
    parameter int VBP = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);
    localparam int HTOT = HD + HFP + HSW + HBP;
    localparam int VTOT = VD + VFP + VSW + VBP;
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(HTOT - 1);
    localparam logic [9:0] V_LAST   = 10'(VTOT - 1);
    localparam logic [9:0] H_VIS    = 10'(HD);
    localparam logic [9:0] V_VIS    = 10'(VD);
    localparam logic [9:0] HS_START = 10'(HD + HFP);
    localparam logic [9:0] HS_END   = 10'(HD + HFP + HSW - 1);
    localparam logic [9:0] VS_START = 10'(VD + VFP);
    localparam logic [9:0] VS_END   = 10'(VD + VFP + VSW - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          p_tick;
    logic          h_end;
    logic          v_end;
    logic          hsync_q;
    logic          vsync_q;

    always_comb begin
        p_tick = (div_cnt == DIV_LAST);
        h_end  = (h_cnt == H_LAST);
        v_end  = (v_cnt == V_LAST);
        h_next = h_cnt;
        v_next = v_cnt;
        if (p_tick) begin
            if (h_end) begin
                h_next = '0;
                v_next = v_end ? '0 : v_cnt + 10'd1;
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Sync registers decode the next count so they switch on the same edge as the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_cnt <= p_tick ? '0 : div_cnt + 1'b1;
            h_cnt   <= h_next;
            v_cnt   <= v_next;
            hsync_q <= !((h_next >= HS_START) && (h_next <= HS_END));
            vsync_q <= !((v_next >= VS_START) && (v_next <= VS_END));
        end
    end

    assign vga.p_tick   = p_tick;
    assign vga.pixel_x  = h_cnt;
    assign vga.pixel_y  = v_cnt;
    assign vga.hsync    = hsync_q;
    assign vga.vsync    = vsync_q;
    assign vga.video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
`ifdef VGA_SYNC_FRAME_TICK_EN
    assign vga.f_tick   = p_tick && h_end && v_end;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// Directed bench: full-size instance for reset/line timing, a shrunken DIV=1 instance
// for frame-level vsync, video_on and f_tick behaviour.
module tb_vga_sync;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_s = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_sync_if vif_a();
    vga_sync_if vif_b();

    vga_sync u_a (
        .clk   (clk),
        .reset (reset),
        .vga   (vif_a)
    );

    // Small timing: HTOT=15, VTOT=11, frame = 165 clk at DIV=1.
    vga_sync #(
        .DIV(1), .HD(8), .HFP(2), .HSW(3), .HBP(2),
        .VD(6), .VFP(2), .VSW(2), .VBP(1)
    ) u_b (
        .clk   (clk),
        .reset (reset_s),
        .vga   (vif_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input string tag, input int sel, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (sel)
                0: found = (vif_a.video_on == 1'b0);
                1: found = (vif_a.hsync == 1'b0);
                2: found = (vif_a.hsync == 1'b1);
                3: found = (vif_a.pixel_x == 10'd799);
                4: found = (vif_a.pixel_x == 10'd700);
                5: found = (vif_b.vsync == 1'b0);
                6: found = (vif_b.vsync == 1'b1);
`ifdef VGA_SYNC_FRAME_TICK_EN
                7: found = (vif_b.f_tick == 1'b1);
`endif
                default: found = 1'b0;
            endcase
            if (found) break;
        end
        chk({tag, "_found"}, 32'(found), 32'd1);
    endtask

    initial begin
        int c0;
        int bad;
        logic ev, eh, evs;

        repeat (3) @(negedge clk);
        chk("rst_x", 32'(vif_a.pixel_x), 0);
        chk("rst_y", 32'(vif_a.pixel_y), 0);
        chk("rst_hsync", 32'(vif_a.hsync), 1);
        chk("rst_vsync", 32'(vif_a.vsync), 1);
        chk("rst_video_on", 32'(vif_a.video_on), 1);
        chk("rst_p_tick", 32'(vif_a.p_tick), 0);
        chk("rst_p_tick_div1", 32'(vif_b.p_tick), 1);
`ifdef VGA_SYNC_FRAME_TICK_EN
        chk("rst_f_tick", 32'(vif_a.f_tick), 0);
`endif

        reset = 1'b0;
        reset_s = 1'b0;
        @(negedge clk);
        chk("rel1_p_tick", 32'(vif_a.p_tick), 1);
        chk("rel1_x", 32'(vif_a.pixel_x), 0);
        @(negedge clk);
        chk("rel2_x", 32'(vif_a.pixel_x), 1);
        chk("rel2_p_tick", 32'(vif_a.p_tick), 0);
        @(negedge clk);
        chk("rel3_x_hold", 32'(vif_a.pixel_x), 1);
        @(negedge clk);
        chk("rel4_x", 32'(vif_a.pixel_x), 2);

        wait_for("von_fall", 0, 2000);
        chk("von_fall_x", 32'(vif_a.pixel_x), 640);
        chk("von_fall_y", 32'(vif_a.pixel_y), 0);
        wait_for("hs_fall", 1, 2000);
        c0 = cyc;
        chk("hs_fall_x", 32'(vif_a.pixel_x), 656);
        wait_for("hs_rise", 2, 2000);
        chk("hs_rise_x", 32'(vif_a.pixel_x), 752);
        chk("hs_width_clk", 32'(cyc - c0), 192);

        wait_for("x799", 3, 2000);
        c0 = cyc;
        chk("x799_y", 32'(vif_a.pixel_y), 0);
        repeat (2) @(negedge clk);
        chk("wrap_x", 32'(vif_a.pixel_x), 0);
        chk("wrap_y", 32'(vif_a.pixel_y), 1);
        chk("wrap_video_on", 32'(vif_a.video_on), 1);
        wait_for("x799_l1", 3, 2000);
        chk("line_len_clk", 32'(cyc - c0), 1600);
        chk("x799_l1_y", 32'(vif_a.pixel_y), 1);

        // Mid-hsync reset, applied on an edge where p_tick would advance the counter.
        wait_for("x700", 4, 2000);
        chk("x700_hsync", 32'(vif_a.hsync), 0);
        @(negedge clk);
        chk("x700_p_tick", 32'(vif_a.p_tick), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_x", 32'(vif_a.pixel_x), 0);
        chk("mid_rst_y", 32'(vif_a.pixel_y), 0);
        chk("mid_rst_hsync", 32'(vif_a.hsync), 1);
        chk("mid_rst_p_tick", 32'(vif_a.p_tick), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("restart1_p_tick", 32'(vif_a.p_tick), 1);
        chk("restart1_x", 32'(vif_a.pixel_x), 0);
        @(negedge clk);
        chk("restart2_x", 32'(vif_a.pixel_x), 1);

        // Small instance: compare every cycle of one frame against expected decode.
        bad = 0;
        for (int i = 0; i < 165; i++) begin
            @(negedge clk);
            ev  = (vif_b.pixel_x < 10'd8) && (vif_b.pixel_y < 10'd6);
            eh  = !((vif_b.pixel_x >= 10'd10) && (vif_b.pixel_x <= 10'd12));
            evs = !((vif_b.pixel_y >= 10'd8) && (vif_b.pixel_y <= 10'd9));
            if (vif_b.video_on !== ev || vif_b.hsync !== eh || vif_b.vsync !== evs ||
                vif_b.p_tick !== 1'b1 || vif_b.pixel_x > 10'd14 || vif_b.pixel_y > 10'd10)
                bad++;
        end
        chk("b_frame_decode_errors", 32'(bad), 0);

        wait_for("b_vs_fall", 5, 200);
        c0 = cyc;
        chk("b_vs_fall_y", 32'(vif_b.pixel_y), 8);
        chk("b_vs_fall_x", 32'(vif_b.pixel_x), 0);
        wait_for("b_vs_rise", 6, 200);
        chk("b_vs_width_clk", 32'(cyc - c0), 30);
        chk("b_vs_rise_y", 32'(vif_b.pixel_y), 10);

`ifdef VGA_SYNC_FRAME_TICK_EN
        wait_for("b_ftick", 7, 200);
        c0 = cyc;
        chk("b_ftick_x", 32'(vif_b.pixel_x), 14);
        chk("b_ftick_y", 32'(vif_b.pixel_y), 10);
        @(negedge clk);
        chk("b_ftick_width", 32'(vif_b.f_tick), 0);
        chk("b_after_ftick_x", 32'(vif_b.pixel_x), 0);
        chk("b_after_ftick_y", 32'(vif_b.pixel_y), 0);
        wait_for("b_ftick2", 7, 200);
        chk("b_ftick_period", 32'(cyc - c0), 165);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
